// File: rtl/complex_acc_if.sv
// complex_acc_if: stream bundle between a complex product source, the complex
// accumulator and the consumer of the frame sums.
//
//   clr        - abort the partial frame (upstream -> accumulator)
//   din_valid  - din_i/din_q valid                (upstream -> accumulator)
//   din_ready  - accumulator accepts a sample     (accumulator -> upstream)
//   din_i/q    - signed I/Q product               (upstream -> accumulator)
//   dout_valid - frame sum valid                  (accumulator -> consumer)
//   dout_ready - consumer takes the sum           (consumer -> accumulator)
//   dout_i/q   - signed I/Q frame sum             (accumulator -> consumer)
//
// master: the environment (source + consumer); slave: the accumulator.
interface complex_acc_if #(
  parameter int DIN_WIDTH  = 17,
  parameter int DOUT_WIDTH = 21
);
  logic                         clr;
  logic                         din_valid;
  logic                         din_ready;
  logic signed [DIN_WIDTH-1:0]  din_i;
  logic signed [DIN_WIDTH-1:0]  din_q;
  logic                         dout_valid;
  logic                         dout_ready;
  logic signed [DOUT_WIDTH-1:0] dout_i;
  logic signed [DOUT_WIDTH-1:0] dout_q;

  modport master (
    output clr, din_valid, din_i, din_q, dout_ready,
    input  din_ready, dout_valid, dout_i, dout_q
  );

  modport slave (
    input  clr, din_valid, din_i, din_q, dout_ready,
    output din_ready, dout_valid, dout_i, dout_q
  );
endinterface

// File: rtl/complex_acc.sv
// complex_acc: streaming complex accumulator. Sums ACC_LEN consecutive signed
// I/Q products at full precision and presents each frame sum through a
// one-entry valid/ready output register. The next frame accumulates while the
// previous sum waits for the consumer; only the frame-closing sample stalls.
//
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset (beats clr and any handshake)
//   bus - complex_acc_if.slave: clr, din_valid/din_ready/din_i/din_q,
//         dout_valid/dout_ready/dout_i/dout_q
module complex_acc #(
  parameter  int DIN_WIDTH  = 17,
  parameter  int ACC_LEN    = 16,
  localparam int CNT_WIDTH  = $clog2(ACC_LEN),
  localparam int DOUT_WIDTH = DIN_WIDTH + $clog2(ACC_LEN)
) (
  input logic           clk,
  input logic           rst,
  complex_acc_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(ACC_LEN - 1);
  localparam int                   ExtBits = DOUT_WIDTH - DIN_WIDTH;

  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic signed [DOUT_WIDTH-1:0] acc_re_q, acc_re_d;
  logic signed [DOUT_WIDTH-1:0] acc_im_q, acc_im_d;
  logic signed [DOUT_WIDTH-1:0] out_re_q, out_re_d;
  logic signed [DOUT_WIDTH-1:0] out_im_q, out_im_d;
  logic                         out_valid_q, out_valid_d;

  logic                         last;
  logic                         ready;
  logic                         accept;
  logic signed [DOUT_WIDTH-1:0] ext_re, ext_im;
  logic signed [DOUT_WIDTH-1:0] sum_re, sum_im;

  // Handshake and datapath
  always_comb begin
    last = (cnt_q == CntLast);
    // Only the frame-closing sample must wait, and only while the output
    // register still holds a sum the consumer has not taken this cycle.
    ready  = !bus.clr && !(out_valid_q && !bus.dout_ready && last);
    accept = bus.din_valid && ready;

    ext_re = {{ExtBits{bus.din_i[DIN_WIDTH-1]}}, bus.din_i};
    ext_im = {{ExtBits{bus.din_q[DIN_WIDTH-1]}}, bus.din_q};

    // The first sample of a frame overwrites the accumulator, so no clear
    // cycle is needed between frames.
    if (cnt_q == '0) begin
      sum_re = ext_re;
      sum_im = ext_im;
    end else begin
      sum_re = acc_re_q + ext_re;
      sum_im = acc_im_q + ext_im;
    end
  end

  // Next-state logic
  always_comb begin
    cnt_d       = cnt_q;
    acc_re_d    = acc_re_q;
    acc_im_d    = acc_im_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_valid_d = out_valid_q;

    if (bus.clr) begin
      // Partial frame is dropped; the output register is left alone so a
      // pending sum is still delivered.
      cnt_d    = '0;
      acc_re_d = '0;
      acc_im_d = '0;
    end else if (accept) begin
      acc_re_d = sum_re;
      acc_im_d = sum_im;
      cnt_d    = last ? '0 : cnt_q + CNT_WIDTH'(1);
    end

    if (out_valid_q && bus.dout_ready) begin
      out_valid_d = 1'b0;
    end

    // A frame closing in the same cycle the old sum is taken keeps valid high.
    if (accept && last) begin
      out_re_d    = sum_re;
      out_im_d    = sum_im;
      out_valid_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.din_ready  = ready;
  assign bus.dout_valid = out_valid_q;
  assign bus.dout_i     = out_re_q;
  assign bus.dout_q     = out_im_q;

endmodule
